// File: rtl/soc_spi_pkg.sv
// Shared types for the multi-slave SPI master: FSM states and the latched mode.
package soc_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/soc_spi_clkgen.sv
// SCK timing: half-period counter (div+1 clk cycles) and edge-index counter.
// Edge strobes fire on the last clk cycle of each XFER half-period, so the
// registered sck toggles exactly at the half-period boundary.
module soc_spi_clkgen #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             xfer_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             phase_tick_o,
    output logic             lead_edge_o,
    output logic             trail_edge_o,
    output logic             last_edge_o
);

    localparam int EDGES  = 2 * DATA_W;
    localparam int EDGE_W = $clog2(EDGES + 1);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic              tick;

    // Strobes and next-state; edge_q counts edges already produced, so an even
    // count means the upcoming edge is odd (leading).
    always_comb begin
        tick         = run_i && (cnt_q == div_i);
        phase_tick_o = tick;
        lead_edge_o  = xfer_i && tick && !edge_q[0];
        trail_edge_o = xfer_i && tick && edge_q[0];
        last_edge_o  = xfer_i && tick && (edge_q == EDGE_W'(EDGES - 1));
        cnt_d        = (!run_i || tick) ? '0 : cnt_q + DIV_W'(1);
        edge_d       = !xfer_i ? '0 : (tick ? edge_q + EDGE_W'(1) : edge_q);
    end

    // Counter state; cleared whenever the master is idle / outside XFER.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            edge_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            edge_q <= edge_d;
        end
    end

endmodule

// File: rtl/soc_spi_master_mc.sv
// Multi-slave SPI master: start/busy/done handshake, runtime CPOL/CPHA,
// programmable SCK divider, one-hot active-low slave selects, MSB first.
module soc_spi_master_mc
    import soc_spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4,
    parameter int DIV_W  = 8,
    localparam int CS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  div,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic [NUM_SS-1:0] ss_n,
    output logic              sck,
    output logic              mosi,
    input  logic              miso
);

    spi_state_e        state_q;
    spi_mode_t         mode_q;
    logic [DIV_W-1:0]  div_q;
    logic [DATA_W-1:0] tx_sh_q, rx_sh_q, rx_data_q;
    logic [NUM_SS-1:0] ss_n_q, ss_n_d;
    logic              busy_q, done_q, sck_q, mosi_q;

    logic phase_tick, lead_edge, trail_edge, last_edge;
    logic shift_en, sample_en;

    soc_spi_clkgen #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W)
    ) u_clkgen (
        .clk          (clk),
        .rst_n        (rst_n),
        .run_i        (state_q != IDLE),
        .xfer_i       (state_q == XFER),
        .div_i        (div_q),
        .phase_tick_o (phase_tick),
        .lead_edge_o  (lead_edge),
        .trail_edge_o (trail_edge),
        .last_edge_o  (last_edge)
    );

    // Slave-select decode from the requested index; out-of-range selects none.
    always_comb begin
        ss_n_d = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            ss_n_d[i] = (cs_sel != CS_W'(i));
        end
    end

    // cpha=0 shifts on trailing edges (not the final one), cpha=1 on leading.
    always_comb begin
        shift_en  = mode_q.cpha ? lead_edge : (trail_edge && !last_edge);
        sample_en = mode_q.cpha ? trail_edge : lead_edge;
    end

    // Transfer FSM with all pin outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            div_q     <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            ss_n_q    <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= SETUP;
                        busy_q      <= 1'b1;
                        mode_q.cpol <= cpol;
                        mode_q.cpha <= cpha;
                        div_q       <= div;
                        tx_sh_q     <= tx_data;
                        rx_sh_q     <= '0;
                        ss_n_q      <= ss_n_d;
                        sck_q       <= cpol;
                        // cpha=0 slaves sample the first bit before any SCK edge
                        mosi_q      <= cpha ? 1'b0 : tx_data[DATA_W-1];
                    end
                end
                SETUP: begin
                    sck_q <= mode_q.cpol;
                    if (phase_tick) state_q <= XFER;
                end
                XFER: begin
                    if (lead_edge || trail_edge) sck_q <= ~sck_q;
                    if (shift_en) begin
                        // cpha=0: MSB is already on the pin, advance to the next bit
                        mosi_q  <= mode_q.cpha ? tx_sh_q[DATA_W-1] : tx_sh_q[DATA_W-2];
                        tx_sh_q <= tx_sh_q << 1;
                    end
                    if (sample_en) rx_sh_q <= {rx_sh_q[DATA_W-2:0], miso};
                    if (last_edge) state_q <= HOLD;
                end
                HOLD: begin
                    sck_q <= mode_q.cpol;
                    if (phase_tick) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        ss_n_q    <= '1;
                        mosi_q    <= 1'b0;
                        rx_data_q <= rx_sh_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data = rx_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ss_n    = ss_n_q;
    assign sck     = sck_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_soc_spi_master_mc.sv
// Bench for soc_spi_master_mc: table vectors, hand sequences for the
// multi-cycle corners, and random transfers against an SPI slave model.
module tb_soc_spi_master_mc;

    localparam int DW  = 8;
    localparam int NSS = 5;
    localparam int DVW = 8;
    localparam int CSW = 3;

    logic           clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic           cpol = 1'b0, cpha = 1'b0, miso = 1'b0;
    logic [DVW-1:0] div = '0;
    logic [CSW-1:0] cs_sel = '0;
    logic [DW-1:0]  tx_data = '0;
    logic [DW-1:0]  rx_data;
    logic           busy, done, sck, mosi;
    logic [NSS-1:0] ss_n;

    int errors = 0, checks = 0, cur_id = 0;

    always #5 clk = ~clk;

    soc_spi_master_mc #(.DATA_W(DW), .NUM_SS(NSS), .DIV_W(DVW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cpol    (cpol),
        .cpha    (cpha),
        .div     (div),
        .cs_sel  (cs_sel),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .busy    (busy),
        .done    (done),
        .ss_n    (ss_n),
        .sck     (sck),
        .mosi    (mosi),
        .miso    (miso)
    );

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic [7:0] dv;
        logic [2:0] cs;
        logic [7:0] tx;
        logic [7:0] sw;        // word the slave sends back
        logic [7:0] exp_rx;
        logic [4:0] exp_ss;
        int         exp_busy;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %0h expected %0h", nm, cur_id, act, exp);
        end
    endtask

    // Reference model: selected line low only for an in-range index;
    // every transfer is SETUP + 2*DW half-periods + HOLD, each div+1 cycles.
    function automatic logic [4:0] model_ss(input logic [2:0] cs);
        logic [4:0] m;
        m = '1;
        if (int'(cs) < NSS) m[cs] = 1'b0;
        return m;
    endfunction

    function automatic int model_busy(input logic [7:0] dv);
        return (2 * DW + 2) * (int'(dv) + 1);
    endfunction

    // Advance n cycles, expecting no busy and no done pulse.
    task automatic idle_check(input int n);
        int bad;
        bad = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk("idle_quiet", bad, 0);
    endtask

    // Issue one transfer and play an SPI slave until done. Called at #1 after
    // a posedge with the DUT idle (or in its done cycle); returns in the done cycle.
    task automatic do_xfer(input vec_t v, input int poke);
        int n, busy_n, edges, ss_bad;
        logic prev;
        logic [7:0] cap;
        cpol = v.cpol; cpha = v.cpha; div = v.dv; cs_sel = v.cs; tx_data = v.tx;
        start = 1'b1;
        miso = v.cpha ? 1'b0 : v.sw[7];
        @(posedge clk); #1;
        start = 1'b0;
        // inputs wander during the transfer; the latched copy must be used
        cpol = ~v.cpol; cpha = ~v.cpha; cs_sel = ~v.cs; tx_data = ~v.tx;
        div = 8'($urandom_range(0, 255));
        chk("setup_sck", sck, v.cpol);
        prev = sck; n = 0; busy_n = 0; edges = 0; ss_bad = 0; cap = '0;
        while (done !== 1'b1 && n < v.exp_busy + 20) begin
            if (busy === 1'b1) begin
                busy_n++;
                if (ss_n !== v.exp_ss) ss_bad++;
            end
            if (sck !== prev) begin
                prev = sck;
                edges++;
                if (edges <= 2 * DW) begin
                    if (edges % 2 == 1) begin
                        if (v.cpha) miso = v.sw[7 - (edges - 1) / 2];
                        else        cap = {cap[6:0], mosi};
                    end else begin
                        if (v.cpha)             cap = {cap[6:0], mosi};
                        else if (edges < 2 * DW) miso = v.sw[7 - edges / 2];
                    end
                end
            end
            start = (poke > 0 && busy_n == poke);
            if (start) tx_data = 8'hFF;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("done_seen", done, 1'b1);
        chk("rx_data", rx_data, v.exp_rx);
        chk("mosi_bits", cap, v.tx);
        chk("busy_cycles", busy_n, v.exp_busy);
        chk("sck_edges", edges, 2 * DW);
        chk("ss_during", ss_bad, 0);
        chk("done_pins", {busy, ss_n, sck, mosi}, {1'b0, 5'h1f, v.cpol, 1'b0});
    endtask

    initial begin
        vec_t v;
        //          cpol  cpha  div    cs    tx     slave  exp_rx ss        busy
        tbl[0] = '{1'b0, 1'b0, 8'd1,  3'd2, 8'hA5, 8'h3C, 8'h3C, 5'b11011, 36};
        tbl[1] = '{1'b0, 1'b0, 8'd2,  3'd0, 8'h81, 8'h7E, 8'h7E, 5'b11110, 54};
        tbl[2] = '{1'b0, 1'b1, 8'd2,  3'd0, 8'h81, 8'h7E, 8'h7E, 5'b11110, 54};
        tbl[3] = '{1'b1, 1'b0, 8'd2,  3'd0, 8'h81, 8'h7E, 8'h7E, 5'b11110, 54};
        tbl[4] = '{1'b1, 1'b1, 8'd2,  3'd0, 8'h81, 8'h7E, 8'h7E, 5'b11110, 54};
        tbl[5] = '{1'b0, 1'b0, 8'd0,  3'd5, 8'h5A, 8'hC3, 8'hC3, 5'b11111, 18};
        tbl[6] = '{1'b1, 1'b0, 8'hFF, 3'd4, 8'h00, 8'hFF, 8'hFF, 5'b01111, 4608};
        tbl[7] = '{1'b1, 1'b1, 8'd3,  3'd7, 8'h3C, 8'h96, 8'h96, 5'b11111, 72};

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {ss_n, sck, mosi, busy, done, rx_data}, {5'h1f, 4'h0, 8'h00});
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        idle_check(2);

        for (int i = 0; i < 8; i++) begin
            cur_id = i;
            do_xfer(tbl[i], 0);
            idle_check(2);
        end

        // second start at busy cycle 5 must be ignored
        cur_id = 100;
        do_xfer(tbl[0], 5);
        idle_check(3);

        // back-to-back at div=0: next start lands in the done cycle
        cur_id = 101;
        v = '{1'b0, 1'b0, 8'd0, 3'd1, 8'hC3, 8'h5A, 8'h5A, 5'b11101, 18};
        do_xfer(v, 0);
        cur_id = 102;
        v = '{1'b1, 1'b1, 8'd0, 3'd3, 8'h3C, 8'hE7, 8'hE7, 5'b10111, 18};
        do_xfer(v, 0);
        idle_check(2);

        // asynchronous reset mid-XFER
        cur_id = 200;
        cpol = 1'b1; cpha = 1'b0; div = 8'd1; cs_sel = 3'd1; tx_data = 8'h96;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        chk("pre_reset_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {ss_n, sck, mosi, busy, done, rx_data}, {5'h1f, 4'h0, 8'h00});
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        idle_check(4);
        cur_id = 201;
        v = '{1'b0, 1'b1, 8'd2, 3'd4, 8'h69, 8'hD2, 8'hD2, 5'b01111, 54};
        do_xfer(v, 0);
        idle_check(1);

        // random transfers, occasionally back-to-back
        for (int i = 0; i < 24; i++) begin
            cur_id = 300 + i;
            v.cpol     = 1'($urandom_range(0, 1));
            v.cpha     = 1'($urandom_range(0, 1));
            v.dv       = 8'($urandom_range(0, 4));
            v.cs       = 3'($urandom_range(0, 7));
            v.tx       = 8'($urandom);
            v.sw       = 8'($urandom);
            v.exp_rx   = v.sw;
            v.exp_ss   = model_ss(v.cs);
            v.exp_busy = model_busy(v.dv);
            do_xfer(v, 0);
            if ($urandom_range(0, 1) == 1) idle_check(1);
        end
        idle_check(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
